dpi_stream_sequencer: RTL and testbench

Upstream driver for the per-regex matcher wrappers in the kraaken DPI core. It accepts packet bytes with a flow key, maps the key to a 6-bit stream ID through a 64-entry flow table, and emits the `load_state` / `new_stream_id` / `stream_id` / `enable` / `char_in` / `char_in_vld` / `eop` sequence the wrappers consume. Matcher context is restored before the first character, and each packet is finalised only after the matcher pipeline drains.

---
 rtl/dpi_stream_sequencer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_dpi_stream_sequencer.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpi_stream_sequencer.sv
// -----------------------------------------------------------------------------
// dpi_stream_sequencer
//
// Upstream driver for the per-regex matcher wrappers. Packet bytes arrive with
// a flow key on the sop beat. The key is mapped to a 6-bit stream ID through a
// 64-entry flow table with FIFO eviction. The block then emits the sequence the
// wrappers consume:
//   load_state   (context restore pulse)
//   one WAIT cycle
//   char_in / char_in_vld for each accepted beat
//   EOP_DELAY idle cycles
//   eop          (finalise pulse)
//
// Parameters
//   NUM_REGEX : width of the per-stream enable mask (one bit per wrapper)
//   KEY_W     : flow key width
//   EOP_DELAY : idle cycles between the last char and eop; legal range 1..7
//
// Ports
//   clk, rst_n     : clock, synchronous active-low reset
//   pkt_vld        : input beat valid
//   pkt_ready      : beat accepted when pkt_vld & pkt_ready
//   pkt_data       : packet byte
//   pkt_sop        : first beat of packet; pkt_key is valid on this beat
//   pkt_eop        : last beat of packet; may coincide with pkt_sop
//   pkt_key        : flow key
//   cfg_wr         : enable-mask write strobe
//   cfg_addr       : stream ID to configure
//   cfg_data       : enable mask
//   stream_id      : stream of the current packet
//   new_stream_id  : stream freshly allocated (qualified by load_state)
//   load_state     : one-cycle restore pulse
//   enable         : enable mask of the current stream, held for the packet
//   char_in        : byte to matchers
//   char_in_vld    : char_in valid
//   eop            : one-cycle finalise pulse
//   pkt_count      : packets completed (wraps)
//   drop_count     : orphan beats dropped (wraps)
// -----------------------------------------------------------------------------
module dpi_stream_sequencer #(
  parameter int NUM_REGEX = 8,
  parameter int KEY_W     = 16,
  parameter int EOP_DELAY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pkt_vld,
  output logic                 pkt_ready,
  input  logic [7:0]           pkt_data,
  input  logic                 pkt_sop,
  input  logic                 pkt_eop,
  input  logic [KEY_W-1:0]     pkt_key,
  input  logic                 cfg_wr,
  input  logic [5:0]           cfg_addr,
  input  logic [NUM_REGEX-1:0] cfg_data,
  output logic [5:0]           stream_id,
  output logic                 new_stream_id,
  output logic                 load_state,
  output logic [NUM_REGEX-1:0] enable,
  output logic [7:0]           char_in,
  output logic                 char_in_vld,
  output logic                 eop,
  output logic [15:0]          pkt_count,
  output logic [15:0]          drop_count
);

  localparam int          NUM_STREAMS = 64;
  // DRAIN holds the cycle that shows the last char plus EOP_DELAY idle cycles,
  // so the counter runs 0..EOP_DELAY before moving to EOP.
  localparam logic [2:0]  DRAIN_LAST  = 3'(EOP_DELAY);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    LOAD,
    WAIT,
    STREAM,
    DRAIN,
    EOP
  } state_t;

  state_t state_q, state_d;

  // Flow table
  logic [KEY_W-1:0]     key_tab  [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] valid_tab;
  logic [NUM_REGEX-1:0] mask_tab [NUM_STREAMS];
  logic [5:0]           alloc_ptr;

  // Sequencing state
  logic [2:0]           drain_cnt;
  logic                 got_beat;   // a beat of the current packet was taken

  // Lookup results
  logic                 lookup_hit;
  logic [5:0]           hit_idx;
  logic [5:0]           lookup_sid;

  logic                 beat_accept;

  assign beat_accept = pkt_vld & pkt_ready;

  // ---------------------------------------------------------------------------
  // Parallel key match. Scanning from the top down lets the lowest matching
  // index win if more than one entry ever matches.
  // ---------------------------------------------------------------------------
  always_comb begin
    lookup_hit = 1'b0;
    hit_idx    = '0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      if (valid_tab[i] && (key_tab[i] == pkt_key)) begin
        lookup_hit = 1'b1;
        hit_idx    = 6'(i);
      end
    end
  end

  assign lookup_sid = lookup_hit ? hit_idx : alloc_ptr;

  // ---------------------------------------------------------------------------
  // FSM next state and beat handshake
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pkt_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pkt_vld) begin
          if (pkt_sop) begin
            // The sop beat stays on the bus; it is taken in STREAM.
            state_d = LOOKUP;
          end else begin
            // Orphan beat: swallow it.
            pkt_ready = 1'b1;
          end
        end
      end
      LOOKUP: state_d = LOAD;
      LOAD:   state_d = WAIT;
      WAIT:   state_d = STREAM;
      STREAM: begin
        if (pkt_vld && pkt_sop && got_beat) begin
          // Next packet started without an eop: close this one and leave the
          // new sop beat waiting for IDLE.
          state_d = DRAIN;
        end else begin
          pkt_ready = 1'b1;
          if (pkt_vld && pkt_eop) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_d = EOP;
        end
      end
      EOP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign load_state = (state_q == LOAD);
  assign eop        = (state_q == EOP);

  // ---------------------------------------------------------------------------
  // State, sequencing and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      drain_cnt     <= '0;
      got_beat      <= 1'b0;
      stream_id     <= '0;
      new_stream_id <= 1'b0;
      enable        <= '0;
      char_in       <= '0;
      char_in_vld   <= 1'b0;
      pkt_count     <= '0;
      drop_count    <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == DRAIN) begin
        drain_cnt <= drain_cnt + 3'd1;
      end else begin
        drain_cnt <= '0;
      end

      if (state_q == WAIT) begin
        got_beat <= 1'b0;
      end else if ((state_q == STREAM) && beat_accept) begin
        got_beat <= 1'b1;
      end

      if (state_q == LOOKUP) begin
        stream_id     <= lookup_sid;
        new_stream_id <= ~lookup_hit;
        // Mask read here is the value before any same-cycle cfg write, so a
        // write to the active stream only shows up on its next packet.
        enable        <= mask_tab[lookup_sid];
      end

      char_in_vld <= (state_q == STREAM) && beat_accept;
      if ((state_q == STREAM) && beat_accept) begin
        char_in <= pkt_data;
      end

      if ((state_q == IDLE) && beat_accept) begin
        drop_count <= drop_count + 16'd1;
      end

      if (state_q == EOP) begin
        pkt_count <= pkt_count + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Flow table valid bits and FIFO allocation pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_tab <= '0;
      alloc_ptr <= '0;
    end else if ((state_q == LOOKUP) && !lookup_hit) begin
      // Allocation always takes the oldest slot; a valid entry there is simply
      // evicted. The 6-bit pointer wraps at 64 by itself.
      valid_tab[alloc_ptr] <= 1'b1;
      alloc_ptr            <= alloc_ptr + 6'd1;
    end
  end

  // NOTE: key storage has no reset; an entry is only ever compared while its
  // valid bit is set, and valid_tab is cleared on reset. The masks do need a
  // reset (to all-ones), so they live in a separate reset flop array below.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == LOOKUP) && !lookup_hit) begin
      key_tab[alloc_ptr] <= pkt_key;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-stream enable masks. Writable in any state; allocating a stream leaves
  // its mask untouched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        mask_tab[i] <= '1;
      end
    end else if (cfg_wr) begin
      mask_tab[cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dpi_stream_sequencer
//
// Scoreboard bench. The driver issues packets and pushes the expected
// load/char/eop responses, computed from a key->stream map with FIFO slot
// reuse, into queues. A negedge monitor pops and compares whenever the DUT
// shows load_state, char_in_vld or eop.
// -----------------------------------------------------------------------------
module tb_dpi_stream_sequencer;

  localparam int NUM_REGEX = 8;
  localparam int KEY_W     = 16;
  localparam int EOP_DELAY = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 pkt_vld;
  logic                 pkt_ready;
  logic [7:0]           pkt_data;
  logic                 pkt_sop;
  logic                 pkt_eop;
  logic [KEY_W-1:0]     pkt_key;
  logic                 cfg_wr;
  logic [5:0]           cfg_addr;
  logic [NUM_REGEX-1:0] cfg_data;
  logic [5:0]           stream_id;
  logic                 new_stream_id;
  logic                 load_state;
  logic [NUM_REGEX-1:0] enable;
  logic [7:0]           char_in;
  logic                 char_in_vld;
  logic                 eop;
  logic [15:0]          pkt_count;
  logic [15:0]          drop_count;

  dpi_stream_sequencer #(
    .NUM_REGEX (NUM_REGEX),
    .KEY_W     (KEY_W),
    .EOP_DELAY (EOP_DELAY)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pkt_vld       (pkt_vld),
    .pkt_ready     (pkt_ready),
    .pkt_data      (pkt_data),
    .pkt_sop       (pkt_sop),
    .pkt_eop       (pkt_eop),
    .pkt_key       (pkt_key),
    .cfg_wr        (cfg_wr),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .stream_id     (stream_id),
    .new_stream_id (new_stream_id),
    .load_state    (load_state),
    .enable        (enable),
    .char_in       (char_in),
    .char_in_vld   (char_in_vld),
    .eop           (eop),
    .pkt_count     (pkt_count),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: key -> stream map, slot owners, next slot to reuse, masks
  // ---------------------------------------------------------------------------
  int         m_map [int];
  int         m_owner [64];
  int         m_next;
  logic [7:0] m_mask [64];
  int         exp_drops;
  int         exp_pkts;

  function automatic void model_reset();
    m_map.delete();
    foreach (m_owner[i]) m_owner[i] = -1;
    foreach (m_mask[i])  m_mask[i]  = 8'hFF;
    m_next    = 0;
    exp_drops = 0;
    exp_pkts  = 0;
  endfunction

  function automatic void model_lookup(input int key, output logic [5:0] sid, output logic nw);
    if (m_map.exists(key)) begin
      sid = 6'(m_map[key]);
      nw  = 1'b0;
    end else begin
      sid = 6'(m_next);
      if (m_owner[m_next] >= 0) m_map.delete(m_owner[m_next]);
      m_map[key]      = m_next;
      m_owner[m_next] = key;
      m_next          = (m_next + 1) % 64;
      nw              = 1'b1;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard queues and monitor
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [5:0] sid;
    logic       nw;
    logic [7:0] en;
    int         at;    // expected load_state cycle, -1 = not checked
  } load_exp_t;

  typedef struct {
    logic [5:0] sid;
    logic [7:0] en;
    bit         gap;   // check eop distance from the last char
  } eop_exp_t;

  load_exp_t  exp_loads [$];
  eop_exp_t   exp_eops  [$];
  logic [7:0] exp_chars [$];

  load_exp_t  mon_le;
  eop_exp_t   mon_ee;
  logic [7:0] mon_ch;
  logic [5:0] cur_sid;
  logic [7:0] cur_en;
  int         last_char_cyc = 0;
  logic [5:0] seen_sid;
  logic       seen_new;

  always @(negedge clk) begin
    if (load_state) begin
      if (exp_loads.size() == 0) begin
        check("unexpected_load", 32'd1, 32'd0);
      end else begin
        mon_le = exp_loads.pop_front();
        check("load_sid", 32'(stream_id), 32'(mon_le.sid));
        check("load_new", 32'(new_stream_id), 32'(mon_le.nw));
        check("load_enable", 32'(enable), 32'(mon_le.en));
        if (mon_le.at >= 0) check("load_cycle", cyc, mon_le.at);
        cur_sid  = mon_le.sid;
        cur_en   = mon_le.en;
        seen_sid = stream_id;
        seen_new = new_stream_id;
      end
    end
    if (char_in_vld) begin
      if (exp_chars.size() == 0) begin
        check("unexpected_char", 32'd1, 32'd0);
      end else begin
        mon_ch = exp_chars.pop_front();
        check("char", 32'(char_in), 32'(mon_ch));
        check("char_enable", 32'(enable), 32'(cur_en));
        check("char_sid", 32'(stream_id), 32'(cur_sid));
      end
      last_char_cyc = cyc;
    end
    if (eop) begin
      if (exp_eops.size() == 0) begin
        check("unexpected_eop", 32'd1, 32'd0);
      end else begin
        mon_ee = exp_eops.pop_front();
        check("eop_sid", 32'(stream_id), 32'(mon_ee.sid));
        check("eop_enable", 32'(enable), 32'(mon_ee.en));
        if (mon_ee.gap) check("eop_gap", cyc, last_char_cyc + EOP_DELAY + 1);
        check("eop_pkt_count", 32'(pkt_count), 32'(exp_pkts));
        exp_pkts++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  logic [7:0] tx_bytes [$];

  // Drive to posedge+1 and mirror any cfg write that the edge just applied.
  task automatic step();
    @(posedge clk);
    #1;
    if (cfg_wr) begin
      m_mask[cfg_addr] = cfg_data;
      cfg_wr = 1'b0;
    end
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [7:0] d);
    cfg_wr   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    step();
  endtask

  // Sends tx_bytes as one packet. abort_at >= 0 asserts reset instead of
  // presenting that beat and returns with rst_n low.
  task automatic send_pkt(input logic [15:0] key, input bit with_eop, input bit chk_timing,
                          input bit bubbles, input int cfg_at, input logic [5:0] cfg_a,
                          input logic [7:0] cfg_d, input int abort_at);
    logic [5:0] sid;
    logic       nw;
    logic [7:0] en;
    int         t_sop;
    int         len;
    int         wait_n;
    bit         acc;
    load_exp_t  le;
    eop_exp_t   ee;
    len = tx_bytes.size();
    model_lookup(int'(key), sid, nw);
    en    = m_mask[sid];
    t_sop = cyc;
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin
        pkt_vld = 1'b0;
        pkt_sop = 1'b0;
        pkt_eop = 1'b0;
        rst_n   = 1'b0;
        return;
      end
      if (bubbles && i > 0 && $urandom_range(0, 2) == 0) begin
        pkt_vld = 1'b0;
        pkt_sop = 1'b0;
        pkt_eop = 1'b0;
        step();
      end
      pkt_vld  = 1'b1;
      pkt_sop  = (i == 0);
      pkt_eop  = with_eop && (i == len - 1);
      pkt_data = tx_bytes[i];
      pkt_key  = key;
      if (i == 0) begin
        t_sop = cyc;
        le = '{sid, nw, en, (chk_timing ? t_sop + 2 : -1)};
        exp_loads.push_back(le);
      end
      if (i == cfg_at) begin
        cfg_wr   = 1'b1;
        cfg_addr = cfg_a;
        cfg_data = cfg_d;
      end
      acc    = 1'b0;
      wait_n = 0;
      while (!acc && wait_n < 100) begin
        @(negedge clk);
        acc = pkt_ready;
        if (acc && i == 0 && chk_timing) check("first_accept_cycle", cyc, t_sop + 4);
        step();
        wait_n++;
      end
      if (!acc) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
      exp_chars.push_back(tx_bytes[i]);
    end
    pkt_vld = 1'b0;
    pkt_sop = 1'b0;
    pkt_eop = 1'b0;
    ee = '{sid, en, with_eop};
    exp_eops.push_back(ee);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_eops.size() != 0 && n < 300) begin
      step();
      n++;
    end
    if (exp_eops.size() != 0) begin
      check("eop_timeout", exp_eops.size(), 32'd0);
      exp_eops.delete();
      exp_loads.delete();
      exp_chars.delete();
    end
  endtask

  task automatic fill_bytes(input int len);
    tx_bytes.delete();
    for (int i = 0; i < len; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_stream_id"},     32'(stream_id),     32'd0);
    check({tag, "_new_stream_id"}, 32'(new_stream_id), 32'd0);
    check({tag, "_load_state"},    32'(load_state),    32'd0);
    check({tag, "_enable"},        32'(enable),        32'd0);
    check({tag, "_char_in"},       32'(char_in),       32'd0);
    check({tag, "_char_in_vld"},   32'(char_in_vld),   32'd0);
    check({tag, "_eop"},           32'(eop),           32'd0);
    check({tag, "_pkt_count"},     32'(pkt_count),     32'd0);
    check({tag, "_drop_count"},    32'(drop_count),    32'd0);
    check({tag, "_pkt_ready"},     32'(pkt_ready),     32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] rkey;
    rst_n    = 1'b0;
    pkt_vld  = 1'b0;
    pkt_data = '0;
    pkt_sop  = 1'b0;
    pkt_eop  = 1'b0;
    pkt_key  = '0;
    cfg_wr   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    step();
    rst_n = 1'b1;
    step();

    // New flow after reset
    tx_bytes = '{8'h41, 8'h42, 8'h43};
    send_pkt(16'h1234, 1'b1, 1'b1, 1'b0, -1, 6'd0, 8'd0, -1);
    wait_idle();
    check("new_flow_sid", 32'(seen_sid), 32'd0);
    check("new_flow_new", 32'(seen_new), 32'd1);
    check("new_flow_pkt_count", 32'(pkt_count), 32'd1);

    // Hit on the same key
    fill_bytes(2);
    send_pkt(16'h1234, 1'b1, 1'b1, 1'b0, -1, 6'd0, 8'd0, -1);
    wait_idle();
    check("hit_sid", 32'(seen_sid), 32'd0);
    check("hit_new", 32'(seen_new), 32'd0);

    // Mask write on the active stream mid-packet, then the next packet
    fill_bytes(4);
    send_pkt(16'h1234, 1'b1, 1'b1, 1'b0, 2, 6'd0, 8'h05, -1);
    wait_idle();
    fill_bytes(2);
    send_pkt(16'h1234, 1'b1, 1'b1, 1'b0, -1, 6'd0, 8'd0, -1);
    wait_idle();

    // 64 more distinct keys: streams 1..63, then the 65th key evicts stream 0
    for (int i = 0; i < 64; i++) begin
      fill_bytes($urandom_range(1, 2));
      send_pkt(16'h2000 + 16'(i), 1'b1, 1'b1, 1'b0, -1, 6'd0, 8'd0, -1);
      wait_idle();
    end
    check("wrap_sid", 32'(seen_sid), 32'd0);
    check("wrap_new", 32'(seen_new), 32'd1);
    fill_bytes(1);
    send_pkt(16'h1234, 1'b1, 1'b1, 1'b0, -1, 6'd0, 8'd0, -1);
    wait_idle();
    check("evicted_sid", 32'(seen_sid), 32'd1);
    check("evicted_new", 32'(seen_new), 32'd1);

    // Orphan beat in IDLE
    pkt_vld  = 1'b1;
    pkt_sop  = 1'b0;
    pkt_data = 8'h99;
    @(negedge clk);
    check("orphan_ready", 32'(pkt_ready), 32'd1);
    step();
    pkt_vld = 1'b0;
    exp_drops++;
    @(negedge clk);
    check("drop_count", 32'(drop_count), 32'd1);
    step();

    // Missing eop: the next sop closes the packet and must not be lost
    fill_bytes(3);
    send_pkt(16'h3000, 1'b0, 1'b1, 1'b0, -1, 6'd0, 8'd0, -1);
    fill_bytes(2);
    send_pkt(16'h3001, 1'b1, 1'b0, 1'b0, -1, 6'd0, 8'd0, -1);
    wait_idle();

    // Randomised traffic with bubbles and idle-time mask writes
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 3) == 0) cfg_write(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
      case ($urandom_range(0, 3))
        0:       rkey = 16'h1234;
        1:       rkey = 16'h2000 + 16'($urandom_range(1, 4));
        2:       rkey = 16'h4444;
        default: rkey = 16'($urandom_range(0, 65535));
      endcase
      fill_bytes($urandom_range(1, 6));
      send_pkt(rkey, 1'b1, 1'b1, 1'b1, -1, 6'd0, 8'd0, -1);
      wait_idle();
    end
    check("random_drop_count", 32'(drop_count), 32'(exp_drops));

    // Reset mid-STREAM
    fill_bytes(6);
    send_pkt(16'h4444, 1'b1, 1'b1, 1'b0, -1, 6'd0, 8'd0, 3);
    @(negedge clk);
    @(negedge clk);
    check_outputs_zero("midrst");
    check("midrst_chars_left", exp_chars.size(), 32'd0);
    check("midrst_loads_left", exp_loads.size(), 32'd0);
    model_reset();
    step();
    rst_n = 1'b1;
    step();
    step();

    // Table was cleared: the same key allocates stream 0 again
    fill_bytes(2);
    send_pkt(16'h4444, 1'b1, 1'b1, 1'b0, -1, 6'd0, 8'd0, -1);
    wait_idle();
    check("post_rst_sid", 32'(seen_sid), 32'd0);
    check("post_rst_new", 32'(seen_new), 32'd1);
    check("post_rst_pkt_count", 32'(pkt_count), 32'd1);

    repeat (4) step();
    check("final_loads_left", exp_loads.size(), 32'd0);
    check("final_chars_left", exp_chars.size(), 32'd0);
    check("final_pkt_count", 32'(pkt_count), 32'(exp_pkts));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
